// File: rtl/redirect_ctrl_if.sv
// Branch-redirect bundle: two branch-pipe request ports, ROB flush, and the
// registered frontend redirect handshake with its accept counter.
interface redirect_ctrl_if #(
    parameter int unsigned ROB_ID_W = 7,
    parameter int unsigned PC_W     = 64
) ();
    logic                bju0_redirect_valid;
    logic [PC_W-1:0]     bju0_redirect_target;
    logic [ROB_ID_W-1:0] bju0_robid;
    logic                bju1_redirect_valid;
    logic [PC_W-1:0]     bju1_redirect_target;
    logic [ROB_ID_W-1:0] bju1_robid;
    logic                rob_flush;
    logic                fe_redirect_ready;
    logic                fe_redirect_valid;
    logic [PC_W-1:0]     fe_redirect_target;
    logic [ROB_ID_W-1:0] fe_redirect_robid;
    logic [31:0]         redirect_cnt;

    modport master (
        output bju0_redirect_valid, bju0_redirect_target, bju0_robid,
        output bju1_redirect_valid, bju1_redirect_target, bju1_robid,
        output rob_flush, fe_redirect_ready,
        input  fe_redirect_valid, fe_redirect_target, fe_redirect_robid, redirect_cnt
    );

    modport slave (
        input  bju0_redirect_valid, bju0_redirect_target, bju0_robid,
        input  bju1_redirect_valid, bju1_redirect_target, bju1_robid,
        input  rob_flush, fe_redirect_ready,
        output fe_redirect_valid, fe_redirect_target, fe_redirect_robid, redirect_cnt
    );
endinterface

// File: rtl/redirect_ctrl.sv
// Arbitrates branch redirects from two pipes by ROB age and holds the oldest
// one for the frontend until accepted; ROB flush overrides everything.
module redirect_ctrl #(
    parameter int unsigned ROB_ID_W = 7,
    parameter int unsigned PC_W     = 64
) (
    input logic             clock,
    input logic             reset,
    redirect_ctrl_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StPend} state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     target_q, target_d;
    logic [ROB_ID_W-1:0] robid_q, robid_d;
    logic [31:0]         cnt_q, cnt_d;

    logic                cand_valid;
    logic [PC_W-1:0]     cand_target;
    logic [ROB_ID_W-1:0] cand_robid;
    logic                handshake;

    // Wrap bit flips each time the ROB index rolls over, so a differing wrap
    // bit inverts the index ordering.
    function automatic logic is_older(input logic [ROB_ID_W-1:0] a,
                                      input logic [ROB_ID_W-1:0] b);
        if (a[ROB_ID_W-1] == b[ROB_ID_W-1]) begin
            return a[ROB_ID_W-2:0] < b[ROB_ID_W-2:0];
        end
        return a[ROB_ID_W-2:0] > b[ROB_ID_W-2:0];
    endfunction

    always_comb begin
        cand_valid  = bus.bju0_redirect_valid | bus.bju1_redirect_valid;
        cand_target = bus.bju0_redirect_target;
        cand_robid  = bus.bju0_robid;
        // Pipe 1 wins only when strictly older, so equal ids go to pipe 0.
        if (bus.bju1_redirect_valid &&
            (!bus.bju0_redirect_valid || is_older(bus.bju1_robid, bus.bju0_robid))) begin
            cand_target = bus.bju1_redirect_target;
            cand_robid  = bus.bju1_robid;
        end
    end

    assign handshake = (state_q == StPend) && bus.fe_redirect_ready;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        robid_d  = robid_q;
        cnt_d    = cnt_q;
        if (bus.rob_flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cand_valid) begin
                        state_d  = StPend;
                        target_d = cand_target;
                        robid_d  = cand_robid;
                    end
                end
                StPend: begin
                    if (handshake) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                    if (cand_valid && is_older(cand_robid, robid_q)) begin
                        target_d = cand_target;
                        robid_d  = cand_robid;
                    end else if (handshake) begin
                        // Younger candidates sit on the path being squashed.
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            target_q <= '0;
            robid_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            robid_q  <= robid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.fe_redirect_valid  = (state_q == StPend);
    assign bus.fe_redirect_target = target_q;
    assign bus.fe_redirect_robid  = robid_q;
    assign bus.redirect_cnt       = cnt_q;
endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl: age arbitration, backpressure,
// handshake collisions, flush and asynchronous reset.
module tb_redirect_ctrl;
    localparam int unsigned ROB_ID_W = 7;
    localparam int unsigned PC_W     = 64;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    redirect_ctrl_if #(.ROB_ID_W(ROB_ID_W), .PC_W(PC_W)) bus ();

    redirect_ctrl #(.ROB_ID_W(ROB_ID_W), .PC_W(PC_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs();
        bus.bju0_redirect_valid  = 1'b0;
        bus.bju0_redirect_target = '0;
        bus.bju0_robid           = '0;
        bus.bju1_redirect_valid  = 1'b0;
        bus.bju1_redirect_target = '0;
        bus.bju1_robid           = '0;
        bus.rob_flush            = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input logic [ROB_ID_W-1:0] rid, input logic [PC_W-1:0] tgt);
        bus.bju0_redirect_valid  = 1'b1;
        bus.bju0_robid           = rid;
        bus.bju0_redirect_target = tgt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus.fe_redirect_ready = 1'b0;
        #1;
        n_checks++; if (bus.fe_redirect_valid !== 1'b0) begin n_errors++;
            $display("FAIL reset_valid got %0b want 0", bus.fe_redirect_valid); end
        n_checks++; if (bus.fe_redirect_target !== 64'h0) begin n_errors++;
            $display("FAIL reset_target got %h want 0", bus.fe_redirect_target); end
        n_checks++; if (bus.fe_redirect_robid !== 7'h0) begin n_errors++;
            $display("FAIL reset_robid got %h want 0", bus.fe_redirect_robid); end
        n_checks++; if (bus.redirect_cnt !== 32'd0) begin n_errors++;
            $display("FAIL reset_cnt got %0d want 0", bus.redirect_cnt); end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        bus.fe_redirect_ready = 1'b1;
        drive0(7'h05, 64'h8000_1000);
        tick();
        clear_inputs();
        n_checks++; if (bus.fe_redirect_valid !== 1'b1) begin n_errors++;
            $display("FAIL single_valid got %0b want 1", bus.fe_redirect_valid); end
        n_checks++; if (bus.fe_redirect_target !== 64'h8000_1000) begin n_errors++;
            $display("FAIL single_target got %h want 80001000", bus.fe_redirect_target); end
        n_checks++; if (bus.fe_redirect_robid !== 7'h05) begin n_errors++;
            $display("FAIL single_robid got %h want 05", bus.fe_redirect_robid); end
        n_checks++; if (bus.redirect_cnt !== 32'd0) begin n_errors++;
            $display("FAIL single_cnt_before got %0d want 0", bus.redirect_cnt); end
        tick();
        n_checks++; if (bus.fe_redirect_valid !== 1'b0) begin n_errors++;
            $display("FAIL single_done_valid got %0b want 0", bus.fe_redirect_valid); end
        n_checks++; if (bus.redirect_cnt !== 32'd1) begin n_errors++;
            $display("FAIL single_cnt got %0d want 1", bus.redirect_cnt); end
    endtask

    task automatic test_dual_wrap();
        bus.fe_redirect_ready = 1'b0;
        drive0(7'h45, 64'hAAAA);
        bus.bju1_redirect_valid  = 1'b1;
        bus.bju1_robid           = 7'h3E;
        bus.bju1_redirect_target = 64'hBBBB;
        tick();
        clear_inputs();
        n_checks++; if (bus.fe_redirect_robid !== 7'h3E) begin n_errors++;
            $display("FAIL dual_wrap_robid got %h want 3e", bus.fe_redirect_robid); end
        n_checks++; if (bus.fe_redirect_target !== 64'hBBBB) begin n_errors++;
            $display("FAIL dual_wrap_target got %h want bbbb", bus.fe_redirect_target); end
        bus.fe_redirect_ready = 1'b1;
        tick();
        n_checks++; if (bus.redirect_cnt !== 32'd2) begin n_errors++;
            $display("FAIL dual_wrap_cnt got %0d want 2", bus.redirect_cnt); end
        // Equal ids: pipe 0 must win.
        bus.fe_redirect_ready = 1'b0;
        drive0(7'h20, 64'hC0C0);
        bus.bju1_redirect_valid  = 1'b1;
        bus.bju1_robid           = 7'h20;
        bus.bju1_redirect_target = 64'hD0D0;
        tick();
        clear_inputs();
        n_checks++; if (bus.fe_redirect_target !== 64'hC0C0) begin n_errors++;
            $display("FAIL dual_equal_target got %h want c0c0", bus.fe_redirect_target); end
        bus.fe_redirect_ready = 1'b1;
        tick();
        n_checks++; if (bus.fe_redirect_valid !== 1'b0 || bus.redirect_cnt !== 32'd3) begin
            n_errors++;
            $display("FAIL dual_equal_drain got valid=%0b cnt=%0d want valid=0 cnt=3",
                     bus.fe_redirect_valid, bus.redirect_cnt); end
    endtask

    task automatic test_backpressure();
        bus.fe_redirect_ready = 1'b0;
        drive0(7'h10, 64'h1000);
        tick();
        drive0(7'h0C, 64'h2000);
        tick();
        n_checks++; if (bus.fe_redirect_robid !== 7'h0C || bus.fe_redirect_target !== 64'h2000)
        begin n_errors++;
            $display("FAIL bp_older got robid=%h target=%h want 0c/2000",
                     bus.fe_redirect_robid, bus.fe_redirect_target); end
        drive0(7'h12, 64'h3000);
        tick();
        clear_inputs();
        n_checks++; if (bus.fe_redirect_robid !== 7'h0C || bus.fe_redirect_target !== 64'h2000
                        || bus.fe_redirect_valid !== 1'b1) begin n_errors++;
            $display("FAIL bp_younger got v=%0b robid=%h target=%h want 1/0c/2000",
                     bus.fe_redirect_valid, bus.fe_redirect_robid, bus.fe_redirect_target); end
        bus.fe_redirect_ready = 1'b1;
        tick();
        n_checks++; if (bus.redirect_cnt !== 32'd4) begin n_errors++;
            $display("FAIL bp_cnt got %0d want 4", bus.redirect_cnt); end
    endtask

    task automatic test_handshake_collision();
        bus.fe_redirect_ready = 1'b0;
        drive0(7'h10, 64'h1000);
        tick();
        bus.fe_redirect_ready = 1'b1;
        drive0(7'h08, 64'h4000);
        tick();
        n_checks++; if (bus.fe_redirect_valid !== 1'b1 || bus.fe_redirect_robid !== 7'h08)
        begin n_errors++;
            $display("FAIL hs_older got v=%0b robid=%h want 1/08",
                     bus.fe_redirect_valid, bus.fe_redirect_robid); end
        n_checks++; if (bus.redirect_cnt !== 32'd5) begin n_errors++;
            $display("FAIL hs_older_cnt got %0d want 5", bus.redirect_cnt); end
        drive0(7'h14, 64'h5000);
        tick();
        clear_inputs();
        n_checks++; if (bus.fe_redirect_valid !== 1'b0 || bus.redirect_cnt !== 32'd6) begin
            n_errors++;
            $display("FAIL hs_younger got v=%0b cnt=%0d want 0/6",
                     bus.fe_redirect_valid, bus.redirect_cnt); end
    endtask

    task automatic test_flush();
        bus.fe_redirect_ready = 1'b0;
        drive0(7'h10, 64'h1000);
        tick();
        bus.fe_redirect_ready = 1'b1;
        bus.rob_flush = 1'b1;
        drive0(7'h02, 64'h6000);
        tick();
        clear_inputs();
        n_checks++; if (bus.fe_redirect_valid !== 1'b0 || bus.redirect_cnt !== 32'd6) begin
            n_errors++;
            $display("FAIL flush got v=%0b cnt=%0d want 0/6",
                     bus.fe_redirect_valid, bus.redirect_cnt); end
        tick();
        n_checks++; if (bus.fe_redirect_valid !== 1'b0 || bus.redirect_cnt !== 32'd6) begin
            n_errors++;
            $display("FAIL idle_ready got v=%0b cnt=%0d want 0/6",
                     bus.fe_redirect_valid, bus.redirect_cnt); end
    endtask

    task automatic test_async_reset();
        bus.fe_redirect_ready = 1'b0;
        drive0(7'h10, 64'h1000);
        tick();
        clear_inputs();
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.fe_redirect_valid !== 1'b0 || bus.redirect_cnt !== 32'd0 ||
                        bus.fe_redirect_robid !== 7'h0) begin n_errors++;
            $display("FAIL async_reset got v=%0b cnt=%0d robid=%h want 0/0/00",
                     bus.fe_redirect_valid, bus.redirect_cnt, bus.fe_redirect_robid); end
        reset = 1'b0;
        drive0(7'h07, 64'h7000);
        tick();
        clear_inputs();
        n_checks++; if (bus.fe_redirect_valid !== 1'b1 || bus.fe_redirect_robid !== 7'h07 ||
                        bus.fe_redirect_target !== 64'h7000) begin n_errors++;
            $display("FAIL post_reset got v=%0b robid=%h target=%h want 1/07/7000",
                     bus.fe_redirect_valid, bus.fe_redirect_robid, bus.fe_redirect_target); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_wrap();
        test_backpressure();
        test_handshake_collision();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/redirect_ctrl.md
REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 The module SHALL have parameter ROB_ID_W, default 7, meaning ROB index width including the MSB wrap bit.
REQ-002 The module SHALL have parameter PC_W, default 64, meaning redirect target width.
REQ-003 The module SHALL have port clock, input, 1, meaning the single clock for all state.
REQ-004 The module SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 The module SHALL have port bju0_redirect_valid, input, 1, meaning branch pipe 0 requests a redirect this cycle.
REQ-006 The module SHALL have port bju0_redirect_target, input, PC_W, meaning branch pipe 0 redirect PC.
REQ-007 The module SHALL have port bju0_robid, input, ROB_ID_W, meaning ROB id of the pipe 0 branch.
REQ-008 The module SHALL have ports bju1_redirect_valid, bju1_redirect_target and bju1_robid, identical to REQ-005..007, for branch pipe 1.
REQ-009 The module SHALL have port rob_flush, input, 1, meaning a ROB exception/commit flush that supersedes every branch redirect.
REQ-010 The module SHALL have port fe_redirect_ready, input, 1, meaning the frontend accepts the redirect this cycle.
REQ-011 The module SHALL have port fe_redirect_valid, output, 1, meaning a registered redirect is offered to the frontend.
REQ-012 The module SHALL have port fe_redirect_target, output, PC_W, meaning the offered redirect PC.
REQ-013 The module SHALL have port fe_redirect_robid, output, ROB_ID_W, meaning the ROB id of the offered redirecting branch, used for the backend squash.
REQ-014 The module SHALL have port redirect_cnt, output, 32, meaning the count of accepted redirects.

Function
REQ-015 The age rule SHALL be: a is older than b when wrap bits are equal and idx(a) < idx(b), or when wrap bits differ and idx(a) > idx(b).
REQ-016 The module SHALL select an incoming candidate each cycle: the only valid port, or the older of the two when both are valid; on equal ids, pipe 0 wins.
REQ-017 The module SHALL implement exactly two states: IDLE (fe_redirect_valid=0) and PEND (fe_redirect_valid=1 with the target and robid held stable).
REQ-018 In IDLE, a valid candidate in cycle N SHALL be loaded, with fe_redirect_valid=1 in cycle N+1, giving one-cycle latency.
REQ-019 In PEND without a handshake, a candidate older than the held robid SHALL replace the target and robid, valid SHALL stay 1, and a younger or equal candidate SHALL be dropped.
REQ-020 A handshake SHALL be fe_redirect_valid & fe_redirect_ready; in that cycle redirect_cnt SHALL increment by 1 and wrap modulo 2^32.
REQ-021 In a handshake cycle, a candidate older than the held robid SHALL be loaded and the state SHALL stay PEND; otherwise the state SHALL go to IDLE and the candidate SHALL be dropped, because it lies on the squashed path.
REQ-022 rob_flush=1 SHALL force the next state to IDLE and discard both the pending entry and all candidates that cycle, with no counter increment, even if a handshake occurs.
REQ-023 fe_redirect_target and fe_redirect_robid SHALL change only on a load, never while PEND without an older candidate.
REQ-024 fe_redirect_ready while IDLE SHALL have no effect.
REQ-025 All outputs SHALL be driven from registers, with no combinational input-to-output path.

Reset
REQ-026 Asserting reset at any time SHALL immediately set: state IDLE, fe_redirect_valid=0, fe_redirect_target=0, fe_redirect_robid=0, redirect_cnt=0.
REQ-027 Any pending redirect at reset SHALL be lost, and candidates presented in the first cycle after deassertion SHALL be processed normally.

Verification
REQ-028 Bench case, single redirect: bju0 valid, target 0x8000_1000, robid 0x05 at cycle N, ready=1 -> cycle N+1 outputs valid=1, target 0x8000_1000, robid 0x05; cycle N+2 valid=0, cnt=1.
REQ-029 Bench case, dual with wrap: bju0 robid 0x45 (wrap 1, idx 5), bju1 robid 0x3E (wrap 0, idx 62) in the same cycle -> bju1 (0x3E) is selected.
REQ-030 Bench case, backpressure with older replacement: PEND robid 0x10 with ready=0; inject robid 0x0C, target 0x2000 -> output becomes 0x0C/0x2000; then inject 0x12 -> no change.
REQ-031 Bench case, handshake collision: PEND robid 0x10 with ready=1; inject 0x08 the same cycle -> next cycle valid=1, robid 0x08, cnt=1; with 0x14 injected instead -> next cycle valid=0.
REQ-032 Bench case, flush: PEND with ready=1 and rob_flush=1, candidate 0x02 -> next cycle valid=0 and cnt unchanged.
REQ-033 Bench case, async reset mid-PEND: assert reset between clock edges -> valid=0 and cnt=0 before the next edge.
